// File: rtl/i2c_mag_pkg.sv
// Shared constants for the I2C magnetometer responder: default address,
// register map and FSM state encoding.
package i2c_mag_pkg;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h1E;

  localparam logic [7:0] REG_CONFIG = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h01;
  localparam logic [7:0] REG_XH     = 8'h02;
  localparam logic [7:0] REG_XL     = 8'h03;
  localparam logic [7:0] REG_YH     = 8'h04;
  localparam logic [7:0] REG_YL     = 8'h05;
  localparam logic [7:0] REG_ZH     = 8'h06;
  localparam logic [7:0] REG_ZL     = 8'h07;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ADDR     = 4'd1,
    ACK_ADDR = 4'd2,
    PTR      = 4'd3,
    ACK_PTR  = 4'd4,
    WR       = 4'd5,
    ACK_WR   = 4'd6,
    RD       = 4'd7,
    RD_ACK   = 4'd8
  } state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizers on SCL/SDA plus SCL edge and START/STOP detection.
// Detection uses the synchronized value and one extra history flop per line.
module i2c_bus_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  // [0] metastable stage, [1] synchronized value, [2] previous synchronized value
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  assign sda_o      = sda_q[1];
  assign scl_rise_o = scl_q[1] & ~scl_q[2];
  assign scl_fall_o = ~scl_q[1] & scl_q[2];
  assign start_o    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop_o     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/i2c_mag_responder.sv
// I2C target exposing CONFIG, STATUS and a 3-axis sample through a pointer-based
// register map, with a per-burst read snapshot so multi-byte reads never tear.
module i2c_mag_responder
  import i2c_mag_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = DEV_ADDR_DEFAULT,
  parameter logic [7:0] CONFIG_RST = 8'h10
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        SCL,
  inout  wire         SDA,
  input  logic [15:0] X_in,
  input  logic [15:0] Y_in,
  input  logic [15:0] Z_in,
  input  logic        sample_valid,
  output logic [7:0]  config_out,
  output logic        busy,
  output logic [3:0]  dbg_state_o
);

  logic sda_s, scl_rise, scl_fall, bus_start, bus_stop;

  i2c_bus_sync u_sync (
    .clk_i      (clk),
    .rst_ni     (reset_l),
    .scl_i      (SCL),
    .sda_i      (SDA),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (bus_start),
    .stop_o     (bus_stop)
  );

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d, tx_q, tx_d, ptr_q, ptr_d, config_q, config_d;
  logic [47:0] shadow_q, shadow_d, snap_q, snap_d, pend_data_q, pend_data_d;
  logic        pend_q, pend_d, burst_q, burst_d, drdy_q, drdy_d, busy_q, busy_d;
  logic        sda_oe_q, sda_oe_d, rw_q, rw_d, ack_q, ack_d;
  logic [7:0]  rd_byte;
  logic [7:0]  shift_in;

  assign shift_in = {shift_q[6:0], sda_s};

  // Status is live; axis bytes come from the snapshot taken at address ACK.
  always_comb begin
    case (ptr_q)
      REG_CONFIG: rd_byte = config_q;
      REG_STATUS: rd_byte = {7'b0, drdy_q};
      REG_XH:     rd_byte = snap_q[47:40];
      REG_XL:     rd_byte = snap_q[39:32];
      REG_YH:     rd_byte = snap_q[31:24];
      REG_YL:     rd_byte = snap_q[23:16];
      REG_ZH:     rd_byte = snap_q[15:8];
      REG_ZL:     rd_byte = snap_q[7:0];
      default:    rd_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    ptr_d       = ptr_q;
    config_d    = config_q;
    shadow_d    = shadow_q;
    snap_d      = snap_q;
    pend_data_d = pend_data_q;
    pend_d      = pend_q;
    burst_d     = burst_q;
    drdy_d      = drdy_q;
    busy_d      = busy_q;
    sda_oe_d    = sda_oe_q;
    rw_d        = rw_q;
    ack_d       = ack_q;

    case (state_q)
      ADDR, PTR, WR: begin
        if (scl_rise) begin
          shift_d = shift_in;
          cnt_d   = cnt_q + 4'd1;
        end
        if (scl_fall && cnt_q == 4'd8) begin
          if (state_q == ADDR) begin
            if (shift_q[7:1] == DEV_ADDR) begin
              state_d  = ACK_ADDR;
              sda_oe_d = 1'b1;
              rw_d     = shift_q[0];
              busy_d   = 1'b1;
              if (shift_q[0]) begin
                snap_d  = shadow_q;
                burst_d = 1'b1;
              end
            end else begin
              state_d = IDLE;
            end
          end else if (state_q == PTR) begin
            ptr_d    = shift_q;
            state_d  = ACK_PTR;
            sda_oe_d = 1'b1;
          end else begin
            if (ptr_q == REG_CONFIG) config_d = shift_q;
            ptr_d    = ptr_q + 8'd1;
            state_d  = ACK_WR;
            sda_oe_d = 1'b1;
          end
        end
      end
      ACK_ADDR: begin
        if (scl_fall) begin
          cnt_d = 4'd0;
          if (rw_q) begin
            state_d  = RD;
            tx_d     = rd_byte;
            sda_oe_d = ~rd_byte[7];
          end else begin
            state_d  = PTR;
            sda_oe_d = 1'b0;
          end
        end
      end
      ACK_PTR, ACK_WR: begin
        if (scl_fall) begin
          state_d  = WR;
          sda_oe_d = 1'b0;
          cnt_d    = 4'd0;
        end
      end
      RD: begin
        if (scl_rise) cnt_d = cnt_q + 4'd1;
        if (scl_fall) begin
          if (cnt_q == 4'd8) begin
            state_d  = RD_ACK;
            sda_oe_d = 1'b0;
            ptr_d    = ptr_q + 8'd1;
          end else begin
            tx_d     = {tx_q[6:0], 1'b0};
            sda_oe_d = ~tx_q[6];
          end
        end
      end
      RD_ACK: begin
        if (scl_rise) begin
          ack_d = ~sda_s;
          // Pointer already advanced, so 0x08 here means ZL was just sent.
          if (ptr_q == REG_ZL + 8'd1) drdy_d = 1'b0;
        end
        if (scl_fall) begin
          if (ack_q) begin
            state_d  = RD;
            tx_d     = rd_byte;
            sda_oe_d = ~rd_byte[7];
            cnt_d    = 4'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: ;
    endcase

    if (bus_start) begin
      state_d  = ADDR;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
    end
    if (bus_stop) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
    end
    if (state_d == IDLE) busy_d = 1'b0;

    // A sample held back during a read burst lands at STOP, after any DRDY clear.
    if (bus_stop && burst_q) begin
      burst_d = 1'b0;
      if (pend_q) begin
        shadow_d = pend_data_q;
        drdy_d   = 1'b1;
        pend_d   = 1'b0;
      end
    end
    if (sample_valid) begin
      if (burst_d) begin
        pend_data_d = {X_in, Y_in, Z_in};
        pend_d      = 1'b1;
      end else begin
        shadow_d = {X_in, Y_in, Z_in};
        drdy_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      shift_q     <= 8'h00;
      tx_q        <= 8'h00;
      ptr_q       <= 8'h00;
      config_q    <= CONFIG_RST;
      shadow_q    <= 48'h0;
      snap_q      <= 48'h0;
      pend_data_q <= 48'h0;
      pend_q      <= 1'b0;
      burst_q     <= 1'b0;
      drdy_q      <= 1'b0;
      busy_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      rw_q        <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      ptr_q       <= ptr_d;
      config_q    <= config_d;
      shadow_q    <= shadow_d;
      snap_q      <= snap_d;
      pend_data_q <= pend_data_d;
      pend_q      <= pend_d;
      burst_q     <= burst_d;
      drdy_q      <= drdy_d;
      busy_q      <= busy_d;
      sda_oe_q    <= sda_oe_d;
      rw_q        <= rw_d;
      ack_q       <= ack_d;
    end
  end

  assign SDA         = sda_oe_q ? 1'b0 : 1'bz;
  assign config_out  = config_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_i2c_mag_responder.sv
// Directed bench for i2c_mag_responder: bit-banged I2C master, expected read
// bytes queued in exp_q, all checks through chk().
module tb_i2c_mag_responder;
  import i2c_mag_pkg::*;

  localparam int T = 80;

  logic        clk;
  logic        reset_l;
  logic        scl;
  logic        m_sda_low;
  logic [15:0] x_in, y_in, z_in;
  logic        sample_valid;
  logic [7:0]  config_out;
  logic        busy;
  logic [3:0]  dbg_state;
  wire         sda_w;

  pullup (sda_w);
  assign sda_w = m_sda_low ? 1'b0 : 1'bz;

  i2c_mag_responder dut (
    .clk          (clk),
    .reset_l      (reset_l),
    .SCL          (scl),
    .SDA          (sda_w),
    .X_in         (x_in),
    .Y_in         (y_in),
    .Z_in         (z_in),
    .sample_valid (sample_valid),
    .config_out   (config_out),
    .busy         (busy),
    .dbg_state_o  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  // Cycles where SDA is low without the master pulling it, and cycles busy is high.
  int low_cnt  = 0;
  int busy_cnt = 0;
  always @(negedge clk) begin
    if (!m_sda_low && sda_w === 1'b0) low_cnt++;
    if (busy === 1'b1) busy_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic i2c_start();
    m_sda_low = 1'b0; #T;
    scl = 1'b1;       #T;
    m_sda_low = 1'b1; #T;
    scl = 1'b0;       #T;
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; #T;
    scl = 1'b1;       #T;
    m_sda_low = 1'b0; #T;
  endtask

  task automatic put_bit(input logic b);
    m_sda_low = ~b; #T;
    scl = 1'b1;     #T;
    scl = 1'b0;     #T;
  endtask

  task automatic get_bit(output logic b);
    m_sda_low = 1'b0; #T;
    scl = 1'b1;       #(T/2);
    b = sda_w;        #(T/2);
    scl = 1'b0;       #T;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(nack);
  endtask

  task automatic set_ptr(input logic [7:0] p);
    logic ack;
    i2c_start();
    write_byte(8'h3C, ack);
    chk("ptr_addr_ack", ack, 1'b1);
    write_byte(p, ack);
    chk("ptr_ack", ack, 1'b1);
  endtask

  // Reads n bytes from pointer p, comparing each against exp_q.
  task automatic read_burst(input logic [7:0] p, input int n);
    logic ack;
    logic [7:0] d;
    set_ptr(p);
    i2c_start();
    write_byte(8'h3D, ack);
    chk("rd_addr_ack", ack, 1'b1);
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, d);
      chk("rd_byte", d, exp_q.pop_front());
    end
    i2c_stop();
  endtask

  task automatic load_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk);
    x_in = x; y_in = y; z_in = z;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  initial begin
    logic ack;
    logic [7:0] d;
    int low0, busy0;

    reset_l = 1'b0;
    scl = 1'b1;
    m_sda_low = 1'b0;
    x_in = '0; y_in = '0; z_in = '0;
    sample_valid = 1'b0;

    #30;
    chk("rst_config", config_out, 8'h10);
    chk("rst_busy", busy, 1'b0);
    chk("rst_state", dbg_state, 4'(IDLE));
    chk("rst_sda", sda_w, 1'b1);
    reset_l = 1'b1;
    #40;

    // write CONFIG = 0x55
    i2c_start();
    write_byte(8'h3C, ack); chk("wr_addr_ack", ack, 1'b1);
    write_byte(8'h00, ack); chk("wr_ptr_ack", ack, 1'b1);
    write_byte(8'h55, ack); chk("wr_data_ack", ack, 1'b1);
    chk("wr_busy", busy, 1'b1);
    i2c_stop();
    #40;
    chk("wr_config", config_out, 8'h55);
    chk("wr_busy_after", busy, 1'b0);

    // read sample, DRDY cleared by reading ZL
    load_sample(16'h1234, 16'hFEDC, 16'h0001);
    exp_q.push_back(8'h01);
    read_burst(8'h01, 1);
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    exp_q.push_back(8'hFE); exp_q.push_back(8'hDC);
    exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    read_burst(8'h02, 6);
    exp_q.push_back(8'h00);
    read_burst(8'h01, 1);

    // anti-tearing: new sample mid-burst held until STOP
    set_ptr(8'h02);
    i2c_start();
    write_byte(8'h3D, ack); chk("tear_addr_ack", ack, 1'b1);
    read_byte(1'b0, d); chk("tear_b1", d, 8'h12);
    load_sample(16'hAAAA, 16'hFEDC, 16'h0001);
    read_byte(1'b1, d); chk("tear_b2", d, 8'h34);
    i2c_stop();
    exp_q.push_back(8'hAA); exp_q.push_back(8'hAA);
    read_burst(8'h02, 2);
    exp_q.push_back(8'h01);
    read_burst(8'h01, 1);

    // address mismatch
    #40;
    low0 = low_cnt;
    busy0 = busy_cnt;
    i2c_start();
    write_byte(8'h40, ack); chk("nomatch_ack", ack, 1'b0);
    i2c_stop();
    #40;
    chk("nomatch_sda_low", low_cnt - low0, 0);
    chk("nomatch_busy", busy_cnt - busy0, 0);
    chk("nomatch_state", dbg_state, 4'(IDLE));

    // pointer wrap 0xFF -> 0x00
    exp_q.push_back(8'h00); exp_q.push_back(8'h55);
    read_burst(8'hFF, 2);

    // reset during a driven-low data bit (ZH = 0x00)
    set_ptr(8'h06);
    i2c_start();
    write_byte(8'h3D, ack); chk("rst_rd_addr_ack", ack, 1'b1);
    m_sda_low = 1'b0;
    #(T/2);
    chk("rst_rd_driven", sda_w, 1'b0);
    #2;
    reset_l = 1'b0;
    #1;
    chk("rst_rd_sda", sda_w, 1'b1);
    chk("rst_rd_state", dbg_state, 4'(IDLE));
    chk("rst_rd_busy", busy, 1'b0);
    #27;
    reset_l = 1'b1;
    scl = 1'b1;
    #80;
    chk("rst_rd_config", config_out, 8'h10);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    read_burst(8'h01, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_mag_responder.md
I2C_MAG_RESPONDER -- requirements
Module: i2c_mag_responder

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h1E: 7-bit I2C target address.
REQ-002 SHALL have parameter CONFIG_RST, default 8'h10: reset value of the CONFIG register.
REQ-003 SHALL have port clk, input, 1: the single system clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port reset_l, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port SCL, input, 1: I2C clock from the master.
REQ-006 SHALL have port SDA, inout, 1: open-drain data line; the block drives only 1'b0 or 1'bz.
REQ-007 SHALL have ports X_in, Y_in and Z_in, input, 16 each: signed axis samples.
REQ-008 SHALL have port sample_valid, input, 1: a 1-cycle pulse that captures X_in, Y_in and Z_in.
REQ-009 SHALL have port config_out, output, 8: current CONFIG register value.
REQ-010 SHALL have port busy, output, 1: high from START to STOP while this device is addressed.

Function
REQ-011 SHALL pass SCL and SDA through 2-flop synchronizers and detect SCL rise and fall from the synchronized values.
REQ-012 SHALL detect START as SDA falling while SCL is high, and STOP as SDA rising while SCL is high; both are recognised in any state.
REQ-013 SHALL implement the register map:
- 0x00 CONFIG, read/write.
- 0x01 STATUS, read-only; bit0 = DRDY, other bits 0.
- 0x02-0x07 XH, XL, YH, YL, ZH, ZL, read-only.
- 0x08-0xFF read as 8'h00; writes to them are ignored.
REQ-014 SHALL, on sample_valid, load a 48-bit shadow from X_in, Y_in and Z_in and set DRDY, unless a read burst is active (see REQ-022).
REQ-015 SHALL use the FSM states IDLE, ADDR, ACK_ADDR, PTR, ACK_PTR, WR, ACK_WR, RD and RD_ACK.
REQ-016 SHALL, in IDLE, move to ADDR on START.
REQ-017 SHALL, in ADDR, shift in 8 bits MSB-first on SCL rises; on a 7-bit match go to ACK_ADDR, otherwise return to IDLE and leave SDA released.
REQ-018 SHALL, in ACK_ADDR, drive SDA low for one SCL period, then go to PTR if R/W=0 or to RD if R/W=1.
REQ-019 SHALL, in PTR, load the 8-bit register pointer, then ACK (ACK_PTR) and go to WR.
REQ-020 SHALL, in WR, write each byte to the register at the pointer, ACK it (ACK_WR), and increment the pointer.
REQ-021 SHALL, in RD, present the register at the pointer MSB-first and increment the pointer after each byte; in RD_ACK, sample the master bit: ACK returns to RD, NACK returns to IDLE.
REQ-022 SHALL latch the shadow into a read-snapshot at ACK_ADDR with R/W=1, so that bytes of one burst never tear; a sample_valid arriving during the burst is held pending and applied at STOP.
REQ-023 SHALL clear DRDY when ZL (0x07) is transmitted and ACKed or NACKed; if a pending sample is applied at the same STOP, the set wins.
REQ-024 SHALL change SDA only in the cycle after a detected SCL fall, i.e. 3 clk cycles or fewer after SCL falls at the pin, and SHALL sample on detected SCL rise.
REQ-025 SHALL wrap the pointer from 0xFF to 0x00.
REQ-026 SHALL, on a repeated START in any state, go to ADDR with the pointer retained; on STOP in any state, go to IDLE.
REQ-027 SHALL assert busy from ACK_ADDR until STOP or return to IDLE.

Reset
REQ-028 SHALL, on reset_l low, immediately set: FSM=IDLE, SDA=z, pointer=0, CONFIG=CONFIG_RST, shadow=0, snapshot=0, DRDY=0, pending=0, busy=0, and synchronizer flops=1.
REQ-029 SHALL, when reset is asserted mid-transaction, release SDA within the same cycle and ignore the bus until the next START.

Structure
REQ-030 SHALL put the register addresses, FSM state encodings and DEV_ADDR default in a shared package, i2c_mag_pkg.
REQ-031 SHALL use one sub-module, i2c_bus_sync, containing the synchronizers, edge detection and START/STOP detection.

Verification
REQ-032 SHALL verify a write: START, 0x3C, 0x00, 0x55, STOP -> three ACKs and config_out=8'h55.
REQ-033 SHALL verify a read: with X=16'h1234, Y=16'hFEDC, Z=16'h0001 loaded, START 0x3C 0x02, repeated START 0x3D, read 6 bytes ACK x5 then NACK -> 12 34 FE DC 00 01, and STATUS then reads 0x00.
REQ-034 SHALL verify anti-tearing: sample_valid with X=16'hAAAA after byte 1 of a burst -> byte 2 = 8'h34, and a later burst returns AA AA.
REQ-035 SHALL verify address mismatch: START 0x40 -> SDA never driven low, busy stays 0.
REQ-036 SHALL verify pointer wrap: pointer 0xFF, read 2 bytes -> 8'h00, then CONFIG.
REQ-037 SHALL verify reset mid-read: reset_l low during a data bit -> SDA=z in the same cycle and FSM=IDLE.
